ps2_key_rx: RTL and testbench
=============================

PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 SHALL have parameter FILT_LEN, default 8, the number of consecutive equal samples needed to accept a PS/2 line level.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65536, the number of clk cycles without a PS/2 clock falling edge that aborts a partial frame.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic runs on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ps2_clk_in, input, 1, the PS/2 clock line, asynchronous to clk.
REQ-006 SHALL have port ps2_data_in, input, 1, the PS/2 data line, asynchronous to clk.
REQ-007 SHALL have port ps2_key, output, 11, the key event word: [10] event toggle, [9] pressed, [8] extended (E0), [7:0] scan code.
REQ-008 SHALL have port frame_err, output, 1, a one-cycle pulse when a frame is discarded.

Function
REQ-009 Each line SHALL pass through a 2-FF synchronizer, then a filter that updates its output only after FILT_LEN identical consecutive samples.
REQ-010 A PS/2 clock fall SHALL be the filtered clock going 1->0; data SHALL be sampled on that same cycle.
REQ-011 The frame FSM SHALL have states IDLE, DATA, PARITY, STOP.
REQ-012 IDLE->DATA SHALL occur on a fall with data=0; a fall with data=1 in IDLE SHALL be ignored with no error.
REQ-013 DATA SHALL shift in 8 bits LSB first, using a 3-bit counter, and then go to PARITY.
REQ-014 PARITY SHALL capture one bit; STOP SHALL accept the frame only if data=1 and the XOR of the 8 data bits and parity is 1 (odd parity).
REQ-015 A bad parity or a stop bit of 0 SHALL pulse frame_err, discard the byte and return to IDLE.
REQ-016 In any state other than IDLE, TIMEOUT_CYC cycles without a fall SHALL pulse frame_err and return to IDLE; the timeout counter SHALL reset on every fall.
REQ-017 Accepted bytes SHALL go to a prefix decoder with flags ext, rel and a 3-bit skip count.
REQ-018 Byte E0 SHALL set ext. Byte F0 SHALL set rel. Byte E1 SHALL load skip=7. While skip!=0, each byte SHALL only decrement skip.
REQ-019 With no prefix pending, bytes AA, FA, EE, FE, FC, 00 and FF SHALL be dropped without an event.
REQ-020 Any other byte SHALL, one clk after the STOP-state acceptance, load ps2_key with {~ps2_key[10], ~rel, ext, byte} and clear ext and rel.
REQ-021 ps2_key[9:0] SHALL change only on the cycle that ps2_key[10] toggles.
REQ-022 A frame error or timeout SHALL also clear ext, rel and skip.
REQ-023 A byte is either a prefix or a code; overlapping events are impossible. A fall arriving in the same cycle as a timeout expiry SHALL take priority and be treated as a fall.

Reset
REQ-024 On reset_n low, without waiting for clk, the following SHALL be forced:
- ps2_key = 11'h000 and frame_err = 0;
- FSM = IDLE;
- counters, ext, rel and skip = 0;
- synchronizer and filter outputs = 1 (idle line).
REQ-025 Reset asserted mid-frame SHALL discard the partial frame with no event and no frame_err.
REQ-026 Release of reset SHALL be synchronized internally before it leaves the flops (asynchronous assert, synchronous deassert).

Structure
REQ-027 Package cpc_ps2_pkg SHALL hold:
- the FSM state enum;
- constants for E0, F0, E1 and the drop-list codes;
- the event word field positions.
REQ-028 A sub-module ps2_line_filter (synchronizer plus FILT_LEN filter) SHALL be instantiated once per line.
REQ-029 The prefix decoder SHALL be an always-block inside ps2_key_rx, not a separate module.

Verification
REQ-030 Frame for 1C (A), valid parity, 80 clk per half-bit -> one toggle of ps2_key[10], ps2_key[9:0] = 10'h21C.
REQ-031 Bytes F0 1C -> single toggle, ps2_key[9:0] = 10'h01C; bytes E0 F0 75 -> single toggle, ps2_key[9:0] = 10'h175.
REQ-032 Frame 1C with flipped parity -> frame_err pulses for exactly 1 cycle, no toggle. A following good 1C -> toggle with 10'h21C and ext clear.
REQ-033 Start bit plus 4 data bits, then idle for TIMEOUT_CYC+1 cycles -> one frame_err pulse. A following good 29 -> ps2_key[7:0] = 29.
REQ-034 Pause sequence E1 14 77 E1 F0 14 F0 77 -> zero toggles. A following 5A -> toggle with 10'h25A.
REQ-035 1-cycle glitches on ps2_clk_in mid-frame -> no extra bits shifted. reset_n pulsed mid-frame -> ps2_key = 000 immediately, no frame_err, and the next full frame decodes correctly.

Source files
------------

// File: rtl/cpc_ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
//   rx_state_e      : frame FSM states
//   CODE_*          : prefix bytes and codes that never produce a key event
//   KEY_*           : bit positions inside the 11-bit key event word
//   is_drop_code()  : true for bytes that carry no key information
package cpc_ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [7:0] CODE_E0 = 8'hE0;  // extended key prefix
  localparam logic [7:0] CODE_F0 = 8'hF0;  // key release prefix
  localparam logic [7:0] CODE_E1 = 8'hE1;  // pause sequence prefix

  localparam logic [7:0] CODE_BAT_OK = 8'hAA;
  localparam logic [7:0] CODE_ACK    = 8'hFA;
  localparam logic [7:0] CODE_ECHO   = 8'hEE;
  localparam logic [7:0] CODE_RESEND = 8'hFE;
  localparam logic [7:0] CODE_BAT_ER = 8'hFC;
  localparam logic [7:0] CODE_OVR0   = 8'h00;
  localparam logic [7:0] CODE_OVR1   = 8'hFF;

  localparam int unsigned KEY_TOG  = 10;
  localparam int unsigned KEY_PRS  = 9;
  localparam int unsigned KEY_EXT  = 8;
  localparam int unsigned KEY_CMSB = 7;

  function automatic logic is_drop_code(input logic [7:0] code);
    return (code == CODE_BAT_OK) || (code == CODE_ACK)    ||
           (code == CODE_ECHO)   || (code == CODE_RESEND) ||
           (code == CODE_BAT_ER) || (code == CODE_OVR0)   ||
           (code == CODE_OVR1);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizer plus level filter for one PS/2 line.
//   clk   : system clock
//   rst_n : async active-low reset (already release-synchronized)
//   raw   : asynchronous PS/2 line
//   level : filtered level; changes only after FILT_LEN consecutive
//           synchronized samples that all differ from the current level
// All flops reset to 1, the idle level of an open-collector PS/2 line.
module ps2_line_filter #(
  parameter int unsigned FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      // Any sample matching the current level restarts the run.
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: frames bytes off the PS/2 lines, strips the
// E0/F0/E1 prefixes and presents key events.
//   clk         : system clock, rising edge
//   reset_n     : async active-low reset, release synchronized internally
//   ps2_clk_in  : PS/2 clock line (asynchronous)
//   ps2_data_in : PS/2 data line (asynchronous)
//   ps2_key     : [10] toggles per event, [9] pressed, [8] extended,
//                 [7:0] scan code
//   frame_err   : one-cycle pulse when a frame is discarded
module ps2_key_rx
  import cpc_ps2_pkg::*;
#(
  parameter int unsigned FILT_LEN    = 8,
  parameter int unsigned TIMEOUT_CYC = 65536
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  // Reset: asserts immediately, releases two clk edges later.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_pipe <= '0;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  logic clk_level;
  logic data_level;
  logic clk_level_q;
  logic fall;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (ps2_clk_in),
    .level (clk_level)
  );

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_data_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (ps2_data_in),
    .level (data_level)
  );

  assign fall = clk_level_q & ~clk_level;

  // Frame FSM
  rx_state_e     state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bit, par_bit_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic          byte_ok;
  logic          err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_level_q <= 1'b1;
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      tmo_cnt     <= '0;
      frame_err   <= 1'b0;
    end else begin
      clk_level_q <= clk_level;
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      par_bit     <= par_bit_n;
      tmo_cnt     <= tmo_cnt_n;
      frame_err   <= err;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    byte_ok   = 1'b0;
    err       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (fall && !data_level) begin
          state_n   = ST_DATA;
          bit_cnt_n = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shreg_n   = {data_level, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_bit_n = data_level;
          state_n   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          if (data_level && ((^shreg) ^ par_bit)) byte_ok = 1'b1;
          else                                    err     = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A fall in the expiry cycle wins over the timeout.
    if (state != ST_IDLE && !fall && tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
      err     = 1'b1;
      state_n = ST_IDLE;
    end

    if (state_n == ST_IDLE || fall) tmo_cnt_n = '0;
    else                            tmo_cnt_n = tmo_cnt + TW'(1);
  end

  // Prefix decoder
  logic       ext;
  logic       rel;
  logic [2:0] skip;
  logic [10:0] event_word;

  always_comb begin
    event_word                   = '0;
    event_word[KEY_TOG]          = ~ps2_key[KEY_TOG];
    event_word[KEY_PRS]          = ~rel;
    event_word[KEY_EXT]          = ext;
    event_word[KEY_CMSB:0]       = shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps2_key <= '0;
      ext     <= 1'b0;
      rel     <= 1'b0;
      skip    <= '0;
    end else if (err) begin
      ext  <= 1'b0;
      rel  <= 1'b0;
      skip <= '0;
    end else if (byte_ok) begin
      if (skip != 3'd0) begin
        skip <= skip - 3'd1;
      end else if (shreg == CODE_E0) begin
        ext <= 1'b1;
      end else if (shreg == CODE_F0) begin
        rel <= 1'b1;
      end else if (shreg == CODE_E1) begin
        skip <= 3'd7;
      end else if (!(is_drop_code(shreg) && !ext && !rel)) begin
        ps2_key <= event_word;
        ext     <= 1'b0;
        rel     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: stimulus pushes expected key words and
// frame errors; a monitor pops and compares when the DUT presents them.
module tb_ps2_key_rx;

  localparam int unsigned TMO = 1000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  int checks = 0;
  int fails  = 0;
  logic [9:0] exp_q[$];
  int err_exp = 0;

  always #5 clk = ~clk;

  ps2_key_rx #(.FILT_LEN(8), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2_clk_in  (ps2_clk),
    .ps2_data_in (ps2_data),
    .ps2_key     (ps2_key),
    .frame_err   (frame_err)
  );

  // Monitor
  logic       last_tog = 1'b0;
  logic [9:0] last_low = '0;
  logic       prev_err = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      last_tog = 1'b0;
      last_low = '0;
      prev_err = 1'b0;
    end else begin
      if (ps2_key[10] !== last_tog) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL event: got ps2_key[9:0]=%h, required no event", ps2_key[9:0]);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if (ps2_key[9:0] !== e) begin
            fails++;
            $display("FAIL event: got ps2_key[9:0]=%h, required %h", ps2_key[9:0], e);
          end
        end
        last_tog = ps2_key[10];
        last_low = ps2_key[9:0];
      end else if (ps2_key[9:0] !== last_low) begin
        checks++;
        fails++;
        $display("FAIL stable: ps2_key[9:0] changed to %h without toggle, required %h",
                 ps2_key[9:0], last_low);
        last_low = ps2_key[9:0];
      end
      if (frame_err === 1'b1) begin
        checks++;
        if (err_exp == 0) begin
          fails++;
          $display("FAIL frame_err: got pulse, required none (prev cycle err=%b)", prev_err);
        end else begin
          err_exp--;
        end
      end
      prev_err = frame_err;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the first nbits of a frame (start, 8 data LSB first, parity, stop).
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit glitch, input int nbits);
    logic [10:0] f;
    logic        par;
    par = (~^b) ^ bad_par;
    f   = {1'b1, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      cyc(40);
      ps2_clk = 1'b0;
      cyc(80);
      ps2_clk = 1'b1;
      if (glitch && (i == 4)) begin
        cyc(10);
        ps2_clk = 1'b0;
        cyc(1);
        ps2_clk = 1'b1;
        cyc(10);
        ps2_clk = 1'b0;
        cyc(1);
        ps2_clk = 1'b1;
        cyc(20);
      end else begin
        cyc(40);
      end
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    cyc(50);
    while ((exp_q.size() != 0 || err_exp != 0) && n < 3000) begin
      cyc(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || err_exp != 0) begin
      fails++;
      $display("FAIL %s: %0d events and %0d errors outstanding, required 0",
               name, exp_q.size(), err_exp);
    end
  endtask

  initial begin
    cyc(5);
    reset_n = 1'b1;
    cyc(30);
    checks++;
    if (ps2_key !== 11'h000 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset: got key=%h err=%b, required 000/0", ps2_key, frame_err);
    end

    exp_q.push_back(10'h21C);
    send_byte(8'h1C);
    drain("make_1c");

    exp_q.push_back(10'h01C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    drain("break_1c");

    exp_q.push_back(10'h175);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    drain("ext_break_75");

    send_byte(8'hAA);
    send_byte(8'hFA);
    drain("drop_codes");

    // Fall with data high in IDLE is ignored.
    ps2_data = 1'b1;
    ps2_clk  = 1'b0;
    cyc(80);
    ps2_clk  = 1'b1;
    cyc(80);
    drain("idle_fall");

    err_exp = 1;
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    drain("bad_parity");
    exp_q.push_back(10'h21C);
    send_byte(8'h1C);
    drain("after_parity");

    // Bad stop bit with a pending E0 prefix: the error clears ext.
    send_byte(8'hE0);
    err_exp = 1;
    send_frame(8'h1C, 1'b0, 1'b0, 10);
    ps2_data = 1'b0;
    cyc(40);
    ps2_clk = 1'b0;
    cyc(80);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    cyc(40);
    drain("bad_stop");
    exp_q.push_back(10'h21C);
    send_byte(8'h1C);
    drain("after_stop");

    err_exp = 1;
    send_frame(8'h00, 1'b0, 1'b0, 5);
    cyc(TMO + 100);
    drain("timeout");
    exp_q.push_back(10'h229);
    send_byte(8'h29);
    drain("after_timeout");

    send_byte(8'hE1);
    send_byte(8'h14);
    send_byte(8'h77);
    send_byte(8'hE1);
    send_byte(8'hF0);
    send_byte(8'h14);
    send_byte(8'hF0);
    send_byte(8'h77);
    drain("pause_seq");
    exp_q.push_back(10'h25A);
    send_byte(8'h5A);
    drain("after_pause");

    exp_q.push_back(10'h21C);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    drain("glitch");

    send_frame(8'h1C, 1'b0, 1'b0, 4);
    cyc(20);
    reset_n = 1'b0;
    #1;
    checks++;
    if (ps2_key !== 11'h000 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got key=%h err=%b, required 000/0", ps2_key, frame_err);
    end
    cyc(5);
    reset_n = 1'b1;
    cyc(30);
    exp_q.push_back(10'h21B);
    send_byte(8'h1B);
    drain("after_reset");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
